// File: rtl/uart_mmio_if.sv
// Load/store bus between the core and the memory-mapped UART.
// The core drives the request fields; the UART returns registered load data.
interface uart_mmio_if;
    logic [31:0] addr;
    logic        en;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (output addr, en, wr, size, data_in, input data_out);
    modport slave  (input addr, en, wr, size, data_in, output data_out);
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: TXDATA/RXDATA/STATUS/BAUDDIV in a 16-byte window,
// TX and RX byte FIFOs, and the serial TX/RX bit engines.
module uart_mmio #(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int unsigned CLK_HZ     = 12000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       CLK,
    input  logic       reset,
    uart_mmio_if.slave bus,
    input  logic       RX,
    output logic       TX
);
    localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] sz);
        logic [31:0] r;
        case (sz)
            3'b000:  r = {{24{d[7]}}, d[7:0]};
            3'b001:  r = {{16{d[15]}}, d[15:0]};
            3'b100:  r = {24'd0, d[7:0]};
            3'b101:  r = {16'd0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    logic [31:0] data_out_r, rdata_s;
    logic [15:0] div_r;
    logic [7:0]  tx_mem_r [FIFO_DEPTH];
    logic [7:0]  rx_mem_r [FIFO_DEPTH];
    logic [PW-1:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
    logic        overrun_r, frame_err_r;
    state_t      tx_state_r, rx_state_r;
    logic [15:0] tx_cnt_r, rx_cnt_r;
    logic [2:0]  tx_bit_r, rx_bit_r;
    logic [7:0]  tx_shift_r, rx_shift_r;
    logic        tx_r;
    logic [1:0]  rx_sync_r;
    logic        rx_prev_r;

    logic        sel_s, ld_s, st_s, clr_s;
    logic [1:0]  reg_s;
    logic        tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
    logic        tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, rx_stop_s, rx_ovf_s, rx_ferr_s;
    logic        rx_in_s;
    logic        unused_s;

    assign sel_s = bus.en & (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign reg_s = bus.addr[3:2];
    assign ld_s  = sel_s & ~bus.wr;
    assign st_s  = sel_s & bus.wr;
    assign clr_s = st_s & (reg_s == 2'd2);
    assign unused_s = ^{bus.addr[1:0], bus.data_in[31:16]};

    // Full/empty come from the wrap bit: equal indices, differing MSB means full.
    assign tx_empty_s = (tx_wptr_r == tx_rptr_r);
    assign tx_full_s  = (tx_wptr_r[PW-1] != tx_rptr_r[PW-1]) && (tx_wptr_r[AW-1:0] == tx_rptr_r[AW-1:0]);
    assign rx_empty_s = (rx_wptr_r == rx_rptr_r);
    assign rx_full_s  = (rx_wptr_r[PW-1] != rx_rptr_r[PW-1]) && (rx_wptr_r[AW-1:0] == rx_rptr_r[AW-1:0]);

    assign tx_push_s = st_s & (reg_s == 2'd0) & ~tx_full_s;
    assign rx_pop_s  = ld_s & (reg_s == 2'd1) & ~rx_empty_s;
    assign tx_pop_s  = ~tx_empty_s & ((tx_state_r == S_IDLE) | ((tx_state_r == S_STOP) & (tx_cnt_r == 16'd0)));
    assign rx_in_s   = rx_sync_r[1];
    assign rx_stop_s = (rx_state_r == S_STOP) & (rx_cnt_r == 16'd0);
    assign rx_push_s = rx_stop_s & rx_in_s & ~rx_full_s;
    assign rx_ovf_s  = rx_stop_s & rx_in_s & rx_full_s;
    assign rx_ferr_s = rx_stop_s & ~rx_in_s;

    assign bus.data_out = data_out_r;
    assign TX = tx_r;

    // Register read mux.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_s)
            2'd0:    rdata_s = 32'd0;
            2'd1:    rdata_s = rx_empty_s ? 32'h0000_0100 : {24'd0, rx_mem_r[rx_rptr_r[AW-1:0]]};
            2'd2:    rdata_s = {26'd0, frame_err_r, overrun_r, rx_full_s, ~rx_empty_s, tx_full_s, tx_empty_s};
            2'd3:    rdata_s = {16'd0, div_r};
            default: rdata_s = 32'd0;
        endcase
    end

    // Load data and baud divisor registers.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            data_out_r <= 32'd0;
            div_r      <= DIV_RST;
        end else begin
            if (ld_s) data_out_r <= load_ext(rdata_s, bus.size);
            if (st_s && (reg_s == 2'd3)) div_r <= (bus.data_in[15:1] == 15'd0) ? 16'd2 : bus.data_in[15:0];
        end
    end

    // FIFO storage.
    always_ff @(posedge CLK) begin
        if (tx_push_s) tx_mem_r[tx_wptr_r[AW-1:0]] <= bus.data_in[7:0];
        if (rx_push_s) rx_mem_r[rx_wptr_r[AW-1:0]] <= rx_shift_r;
    end

    // FIFO pointers and sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tx_wptr_r   <= '0;
            tx_rptr_r   <= '0;
            rx_wptr_r   <= '0;
            rx_rptr_r   <= '0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (tx_push_s) tx_wptr_r <= tx_wptr_r + PW'(1);
            if (tx_pop_s)  tx_rptr_r <= tx_rptr_r + PW'(1);
            if (rx_push_s) rx_wptr_r <= rx_wptr_r + PW'(1);
            if (rx_pop_s)  rx_rptr_r <= rx_rptr_r + PW'(1);
            overrun_r   <= rx_ovf_s  | (overrun_r   & ~clr_s);
            frame_err_r <= rx_ferr_s | (frame_err_r & ~clr_s);
        end
    end

    // TX engine; each bit reloads its counter from div_r so rate changes land on bit boundaries.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            tx_state_r <= S_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            case (tx_state_r)
                S_IDLE: begin
                    if (tx_pop_s) begin
                        tx_shift_r <= tx_mem_r[tx_rptr_r[AW-1:0]];
                        tx_cnt_r   <= div_r - 16'd1;
                        tx_r       <= 1'b0;
                        tx_state_r <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_r == 16'd0) begin
                        tx_cnt_r   <= div_r - 16'd1;
                        tx_r       <= tx_shift_r[0];
                        tx_shift_r <= tx_shift_r >> 1;
                        tx_bit_r   <= 3'd0;
                        tx_state_r <= S_DATA;
                    end else begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_r == 16'd0) begin
                        tx_cnt_r <= div_r - 16'd1;
                        if (tx_bit_r == 3'd7) begin
                            tx_r       <= 1'b1;
                            tx_state_r <= S_STOP;
                        end else begin
                            tx_r       <= tx_shift_r[0];
                            tx_shift_r <= tx_shift_r >> 1;
                            tx_bit_r   <= tx_bit_r + 3'd1;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                S_STOP: begin
                    if (tx_cnt_r == 16'd0) begin
                        if (tx_pop_s) begin
                            tx_shift_r <= tx_mem_r[tx_rptr_r[AW-1:0]];
                            tx_cnt_r   <= div_r - 16'd1;
                            tx_r       <= 1'b0;
                            tx_state_r <= S_START;
                        end else begin
                            tx_state_r <= S_IDLE;
                        end
                    end else begin
                        tx_cnt_r <= tx_cnt_r - 16'd1;
                    end
                end
                default: tx_state_r <= S_IDLE;
            endcase
        end
    end

    // RX synchroniser plus previous sample for falling-edge detection.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rx_sync_r <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            rx_sync_r <= {rx_sync_r[0], RX};
            rx_prev_r <= rx_sync_r[1];
        end
    end

    // RX engine: mid-start check, then samples one bit period apart.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            rx_state_r <= S_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            case (rx_state_r)
                S_IDLE: begin
                    if (rx_prev_r && !rx_in_s) begin
                        rx_cnt_r   <= (div_r >> 1) - 16'd1;
                        rx_state_r <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt_r == 16'd0) begin
                        if (rx_in_s) begin
                            rx_state_r <= S_IDLE;
                        end else begin
                            rx_cnt_r   <= div_r - 16'd1;
                            rx_bit_r   <= 3'd0;
                            rx_state_r <= S_DATA;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_r == 16'd0) begin
                        rx_shift_r <= {rx_in_s, rx_shift_r[7:1]};
                        rx_cnt_r   <= div_r - 16'd1;
                        if (rx_bit_r == 3'd7) begin
                            rx_state_r <= S_STOP;
                        end else begin
                            rx_bit_r <= rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                S_STOP: begin
                    if (rx_cnt_r == 16'd0) begin
                        rx_state_r <= S_IDLE;
                    end else begin
                        rx_cnt_r <= rx_cnt_r - 16'd1;
                    end
                end
                default: rx_state_r <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: loads and TX frames are queued as expectations
// and checked by independent monitor processes.
module tb_uart_mmio;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_RX = BASE + 32'h4;
    localparam logic [31:0] A_ST = BASE + 32'h8;
    localparam logic [31:0] A_BD = BASE + 32'hC;

    logic CLK = 1'b0;
    logic reset = 1'b0;
    logic RX = 1'b1;
    logic TX;

    uart_mmio_if bus ();

    uart_mmio #(.BASE_ADDR(BASE), .CLK_HZ(12000000), .BAUD(115200), .FIFO_DEPTH(16)) dut (
        .CLK(CLK), .reset(reset), .bus(bus), .RX(RX), .TX(TX)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;
    logic [31:0] ld_exp[$];
    logic [7:0]  tx_exp[$];
    logic [31:0] last_ld = 32'd0;
    int  tx_div = 104;
    logic mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_op(input logic w, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.en = 1'b1; bus.wr = w; bus.size = sz; bus.addr = a; bus.data_in = d;
        @(negedge CLK);
        bus.en = 1'b0; bus.wr = 1'b0;
    endtask

    task automatic ld(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] exp);
        ld_exp.push_back(exp);
        last_ld = exp;
        bus_op(1'b0, sz, a, 32'd0);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d);
        bus_op(1'b1, 3'b010, a, d);
    endtask

    task automatic send_rx(input logic [7:0] b, input int div, input logic stop);
        RX = 1'b0;
        repeat (div) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (div) @(negedge CLK);
        end
        RX = stop;
        repeat (div) @(negedge CLK);
        if (!stop) begin
            RX = 1'b1;
            repeat (div) @(negedge CLK);
        end
    endtask

    task automatic wait_tx(input int budget);
        int n = 0;
        while ((tx_exp.size() != 0 || mon_busy) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("tx_drain_timeout", {31'd0, n >= budget}, 32'd0);
        repeat (20) @(negedge CLK);
    endtask

    // Load monitor: any load strobe yields data_out one edge later.
    initial begin
        logic ld_seen;
        forever begin
            @(posedge CLK);
            ld_seen = bus.en & ~bus.wr;
            #1;
            if (ld_seen) begin
                chk("ld_expect_avail", {31'd0, ld_exp.size() != 0}, 32'd1);
                if (ld_exp.size() != 0) chk("ld_data", bus.data_out, ld_exp.pop_front());
            end
        end
    end

    // TX monitor: decodes frames, checks edges fall on bit boundaries.
    initial begin
        int t;
        int k;
        logic prev;
        logic abort;
        logic stop_bit;
        logic [7:0] b;
        forever begin
            @(negedge CLK);
            if (reset && TX == 1'b0) begin
                mon_busy = 1'b1;
                t = 0; prev = 1'b0; abort = 1'b0; b = 8'd0; stop_bit = 1'b0;
                while (t < 9 * tx_div + tx_div / 2 && !abort) begin
                    @(negedge CLK);
                    t++;
                    if (!reset) begin
                        abort = 1'b1;
                    end else begin
                        if (TX !== prev) begin
                            chk("tx_edge_align", t % tx_div, 32'd0);
                            prev = TX;
                        end
                        if ((t % tx_div) == tx_div / 2) begin
                            k = t / tx_div;
                            if (k == 0) chk("tx_start_bit", {31'd0, TX}, 32'd0);
                            else if (k <= 8) b[k-1] = TX;
                            else stop_bit = TX;
                        end
                    end
                end
                if (!abort) begin
                    chk("tx_stop_bit", {31'd0, stop_bit}, 32'd1);
                    chk("tx_expect_avail", {31'd0, tx_exp.size() != 0}, 32'd1);
                    if (tx_exp.size() != 0) chk("tx_byte", {24'd0, b}, {24'd0, tx_exp.pop_front()});
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        bus.en = 1'b0; bus.wr = 1'b0; bus.size = 3'b010; bus.addr = 32'd0; bus.data_in = 32'd0;
        repeat (4) @(negedge CLK);
        chk("reset_tx", {31'd0, TX}, 32'd1);
        chk("reset_data_out", bus.data_out, 32'd0);
        reset = 1'b1;
        @(negedge CLK);

        ld(3'b010, A_BD, 32'd104);
        ld(3'b010, A_ST, 32'h1);

        // Single TX byte: status sampled before and after the pop.
        tx_exp.push_back(8'h5A);
        st(A_TX, 32'h5A);
        ld(3'b010, A_ST, 32'h0);
        ld(3'b010, A_ST, 32'h1);
        wait_tx(3000);

        // Single RX byte, sign-extended byte load, then empty read.
        send_rx(8'hC3, 104, 1'b1);
        ld(3'b010, A_ST, 32'h5);
        ld(3'b000, A_RX, 32'hFFFF_FFC3);
        ld(3'b010, A_RX, 32'h0000_0100);

        // 18 back-to-back stores: one in flight, 16 queued, last dropped.
        for (int i = 0; i < 18; i++) begin
            if (i < 17) tx_exp.push_back(8'(8'h10 + i));
            st(A_TX, 32'h10 + i);
        end
        ld(3'b010, A_ST, 32'h2);
        wait_tx(20000);
        ld(3'b010, A_ST, 32'h1);

        // 17 RX frames into a 16-deep FIFO.
        for (int i = 0; i < 17; i++) send_rx(8'(8'h30 + i), 104, 1'b1);
        ld(3'b010, A_ST, 32'h1D);
        st(A_ST, 32'h0);
        ld(3'b010, A_ST, 32'h0D);
        for (int i = 0; i < 16; i++) ld(3'b100, A_RX, 32'h30 + i);
        ld(3'b010, A_RX, 32'h0000_0100);

        // Framing error, then a short low glitch.
        send_rx(8'h77, 104, 1'b0);
        ld(3'b010, A_ST, 32'h21);
        st(A_ST, 32'hFF);
        ld(3'b010, A_ST, 32'h1);
        RX = 1'b0;
        repeat (40) @(negedge CLK);
        RX = 1'b1;
        repeat (300) @(negedge CLK);
        ld(3'b010, A_ST, 32'h1);
        ld(3'b010, A_RX, 32'h0000_0100);

        // Faster baud in both directions.
        st(A_BD, 32'd52);
        ld(3'b010, A_BD, 32'd52);
        tx_div = 52;
        tx_exp.push_back(8'hA5);
        st(A_TX, 32'hA5);
        wait_tx(2000);
        send_rx(8'hA5, 52, 1'b1);
        ld(3'b000, A_RX, 32'hFFFF_FFA5);
        st(A_BD, 32'd0);
        ld(3'b010, A_BD, 32'd2);
        st(A_BD, 32'd1);
        ld(3'b010, A_BD, 32'd2);
        st(A_BD, 32'd104);
        tx_div = 104;

        // Reset in the middle of a TX frame.
        st(A_TX, 32'h66);
        repeat (150) @(negedge CLK);
        chk("tx_mid_frame_low", {31'd0, TX}, 32'd0);
        #3 reset = 1'b0;
        #1;
        chk("tx_reset_high", {31'd0, TX}, 32'd1);
        chk("reset_data_out_mid", bus.data_out, 32'd0);
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        last_ld = 32'd0;
        @(negedge CLK);
        ld(3'b010, A_BD, 32'd104);
        ld(3'b010, A_ST, 32'h1);

        // Out-of-window accesses must not touch state or data_out.
        st(BASE + 32'h10, 32'h77);
        st(32'h0000_0008, 32'hFF);
        st(BASE + 32'h1C, 32'h10);
        repeat (2000) @(negedge CLK);
        ld(3'b010, A_BD, 32'd104);
        ld(3'b010, BASE + 32'h14, last_ld);
        ld(3'b010, A_ST, 32'h1);

        // Halfword extension and ignored low address bits.
        st(A_BD, 32'h0000_8001);
        ld(3'b001, BASE + 32'hE, 32'hFFFF_8001);
        ld(3'b101, A_BD, 32'h0000_8001);
        ld(3'b010, BASE + 32'hB, 32'h1);

        repeat (10) @(negedge CLK);
        chk("ld_queue_drained", ld_exp.size(), 32'd0);
        chk("tx_queue_drained", tx_exp.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
